// File: rtl/iso7816_rx_pkg.sv
// Shared types and helpers for the ISO7816-3 receive engine.
package iso7816_rx_pkg;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, ERRSIG
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic IDLE_BIT  = 1'b1;

  // acc: running XOR of the data bits, b: received parity bit.
  function automatic logic parity_err(input logic acc, input logic b, input logic odd);
    return (acc ^ b) != odd;
  endfunction

endpackage

// File: rtl/iso7816_rx_if.sv
// Host/line-side signal bundle of the receive engine.
interface iso7816_rx_if #(
  parameter int CLOCK_PER_BIT_WIDTH = 13,
  parameter int DATA_BITS           = 8,
  parameter int FIFO_DEPTH          = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                           serialIn;
  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit;
  logic                           stopBit2;
  logic                           parityEn;
  logic                           oddParity;
  logic                           msbFirst;
  logic                           errSigEn;
  logic                           ackFlags;
  logic [DATA_BITS-1:0]           dataOut;
  logic                           dataValid;
  logic                           dataReady;
  logic [LVL_W-1:0]               fifoLevel;
  logic                           overrunErrorFlag;
  logic                           frameErrorFlag;
  logic                           errSigOut;
  logic                           startBit;
  logic                           run;
  logic                           endOfRx;

  modport slave (
    input  serialIn, clocksPerBit, stopBit2, parityEn, oddParity, msbFirst,
           errSigEn, ackFlags, dataReady,
    output dataOut, dataValid, fifoLevel, overrunErrorFlag, frameErrorFlag,
           errSigOut, startBit, run, endOfRx
  );

  modport master (
    output serialIn, clocksPerBit, stopBit2, parityEn, oddParity, msbFirst,
           errSigEn, ackFlags, dataReady,
    input  dataOut, dataValid, fifoLevel, overrunErrorFlag, frameErrorFlag,
           errSigOut, startBit, run, endOfRx
  );
endinterface

// File: rtl/iso7816_rx_fifo.sv
// Synchronous FIFO; a push while full succeeds when a pop happens in the same cycle.
module iso7816_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_level,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_level;
  logic             w_push, w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_level = r_level;
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/iso7816_rx_engine.sv
// ISO7816-3 character receiver: synchroniser, etu counter, frame FSM with
// T=0 error signalling, and a receive FIFO with sticky error flags.
module iso7816_rx_engine
  import iso7816_rx_pkg::*;
#(
  parameter int CLOCK_PER_BIT_WIDTH = 13,
  parameter int DATA_BITS           = 8,
  parameter int FIFO_DEPTH          = 4,
  parameter int ERR_SIG_ETU         = 2
) (
  input logic         clk,
  input logic         nReset,
  iso7816_rx_if.slave bus
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  state_t                         r_state, w_next;
  logic [1:0]                     r_sync;
  logic                           w_rxs;
  logic [CLOCK_PER_BIT_WIDTH-1:0] r_cnt, r_cpb, w_cmp;
  logic                           w_match;
  logic [BW-1:0]                  r_bit, w_idx;
  logic [DATA_BITS-1:0]           r_data;
  logic                           r_par, r_perr;
  logic [1:0]                     r_etu;
  logic                           r_eor, r_frame, r_ovr;
  logic                           w_push, w_frame_set, w_ovr_set, w_full, w_empty;

  assign w_rxs   = r_sync[1];
  assign w_match = (r_cnt == w_cmp);
  assign w_idx   = bus.msbFirst ? BIT_LAST - r_bit : r_bit;

  // IDLE compares against 0 so the counter stays parked at 0.
  always_comb begin
    w_cmp = r_cpb - 1'b1;
    case (r_state)
      IDLE:    w_cmp = '0;
      START:   w_cmp = (r_cpb >> 1) - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      IDLE:   if (w_rxs == START_BIT) w_next = START;
      START:  if (w_match) w_next = (w_rxs == IDLE_BIT) ? IDLE : DATA;
      DATA:   if (w_match && r_bit == BIT_LAST) w_next = bus.parityEn ? PARITY : STOP1;
      PARITY: if (w_match) w_next = STOP1;
      STOP1: if (w_match) begin
        if (r_perr && bus.errSigEn) begin
          w_next = ERRSIG;
        end else begin
          if (r_perr || w_rxs == START_BIT) w_frame_set = 1'b1;
          else                              w_push      = 1'b1;
          w_next = bus.stopBit2 ? STOP2 : IDLE;
        end
      end
      STOP2: if (w_match) begin
        if (w_rxs == START_BIT) w_frame_set = 1'b1;
        w_next = IDLE;
      end
      // ERR_SIG_ETU etu of low drive followed by one guard etu.
      ERRSIG: if (w_match && r_etu == 2'(ERR_SIG_ETU)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_sync  <= {2{IDLE_BIT}};
      r_cnt   <= '0;
      r_cpb   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_etu   <= '0;
      r_eor   <= 1'b0;
      r_frame <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], bus.serialIn};
      r_cnt  <= (w_next != r_state || w_match) ? '0 : r_cnt + 1'b1;
      r_eor  <= (w_next == IDLE) && !(r_state inside {IDLE, START});
      if (r_state == IDLE && w_rxs == START_BIT) begin
        r_cpb  <= bus.clocksPerBit;
        r_bit  <= '0;
        r_par  <= 1'b0;
        r_perr <= 1'b0;
        r_etu  <= '0;
      end
      if (r_state == DATA && w_match) begin
        r_data[w_idx] <= w_rxs;
        r_par         <= r_par ^ w_rxs;
        r_bit         <= r_bit + 1'b1;
      end
      if (r_state == PARITY && w_match) r_perr <= parity_err(r_par, w_rxs, bus.oddParity);
      if (r_state == ERRSIG && w_match) r_etu  <= r_etu + 1'b1;
      // A set event in the ack cycle wins.
      if (w_frame_set)       r_frame <= 1'b1;
      else if (bus.ackFlags) r_frame <= 1'b0;
      if (w_ovr_set)         r_ovr   <= 1'b1;
      else if (bus.ackFlags) r_ovr   <= 1'b0;
    end
  end

  // Full implies non-empty, so dataReady alone means a pop this cycle.
  assign w_ovr_set = w_push & w_full & ~bus.dataReady;

  iso7816_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .nReset  (nReset),
    .i_push  (w_push),
    .i_pop   (bus.dataReady),
    .i_data  (r_data),
    .o_data  (bus.dataOut),
    .o_level (bus.fifoLevel),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.dataValid        = ~w_empty;
  assign bus.overrunErrorFlag = r_ovr;
  assign bus.frameErrorFlag   = r_frame;
  assign bus.errSigOut        = (r_state == ERRSIG) && (r_etu < 2'(ERR_SIG_ETU));
  assign bus.startBit         = (r_state == START);
  assign bus.run              = r_state inside {DATA, PARITY, STOP1, STOP2, ERRSIG};
  assign bus.endOfRx          = r_eor;
endmodule

// File: tb/tb_iso7816_rx_engine.sv
// Scoreboard bench: expected characters are queued at send time and popped by
// monitors whenever a DUT presents dataValid & dataReady.
module tb_iso7816_rx_engine;
  logic clk = 1'b0;
  logic nReset = 1'b1;
  always #5 clk = ~clk;

  iso7816_rx_if #(.CLOCK_PER_BIT_WIDTH(13), .DATA_BITS(8), .FIFO_DEPTH(4)) bus ();
  iso7816_rx_if #(.CLOCK_PER_BIT_WIDTH(13), .DATA_BITS(7), .FIFO_DEPTH(4)) bus7 ();

  iso7816_rx_engine #(.CLOCK_PER_BIT_WIDTH(13), .DATA_BITS(8), .FIFO_DEPTH(4), .ERR_SIG_ETU(2))
    dut (.clk(clk), .nReset(nReset), .bus(bus));
  iso7816_rx_engine #(.CLOCK_PER_BIT_WIDTH(13), .DATA_BITS(7), .FIFO_DEPTH(4), .ERR_SIG_ETU(2))
    dut7 (.clk(clk), .nReset(nReset), .bus(bus7));

  logic sin  = 1'b1;
  logic sel7 = 1'b0;
  assign bus.serialIn  = sel7 ? 1'b1 : sin;
  assign bus7.serialIn = sel7 ? sin : 1'b1;

  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp7_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observation counters sampled on the falling edge.
  int cyc = 0, eor_cnt = 0, sb_cnt = 0, run_cnt = 0, es_cnt = 0, es_first = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.endOfRx) eor_cnt++;
    if (bus.startBit) sb_cnt++;
    if (bus.run) run_cnt++;
    if (bus.errSigOut) begin
      if (es_cnt == 0) es_first = cyc;
      es_cnt++;
    end
  end

  always @(negedge clk) begin
    if (nReset && bus.dataValid && bus.dataReady) begin
      if (exp_q.size() == 0) chk("pop8 unexpected", int'(bus.dataOut), -1);
      else chk("pop8 data", int'(bus.dataOut), int'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (nReset && bus7.dataValid && bus7.dataReady) begin
      if (exp7_q.size() == 0) chk("pop7 unexpected", int'(bus7.dataOut), -1);
      else chk("pop7 data", int'(bus7.dataOut), int'(exp7_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, data, optional parity (flip corrupts it), stop 1, optional stop 2.
  task automatic send(input logic [8:0] d, input int nb, input logic msb, input logic pen,
                      input logic odd, input logic flip, input logic s2, input int ns,
                      input int cpb);
    logic p;
    p = odd;
    for (int i = 0; i < nb; i++) p ^= d[i];
    sin = 1'b0; tick(cpb);
    for (int i = 0; i < nb; i++) begin
      sin = msb ? d[nb-1-i] : d[i];
      tick(cpb);
    end
    if (pen) begin sin = p ^ flip; tick(cpb); end
    sin = 1'b1; tick(cpb);
    if (ns == 2) begin sin = s2; tick(cpb); end
    sin = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " dataValid"}, int'(bus.dataValid), 0);
    chk({tag, " fifoLevel"}, int'(bus.fifoLevel), 0);
    chk({tag, " dataOut"}, int'(bus.dataOut), 0);
    chk({tag, " frameErr"}, int'(bus.frameErrorFlag), 0);
    chk({tag, " overrun"}, int'(bus.overrunErrorFlag), 0);
    chk({tag, " errSigOut"}, int'(bus.errSigOut), 0);
    chk({tag, " startBit"}, int'(bus.startBit), 0);
    chk({tag, " run"}, int'(bus.run), 0);
    chk({tag, " endOfRx"}, int'(bus.endOfRx), 0);
  endtask

  int e0, s0, r0, es0, c0;

  initial begin
    bus.clocksPerBit = 13'd372; bus.stopBit2 = 0; bus.parityEn = 1; bus.oddParity = 0;
    bus.msbFirst = 0; bus.errSigEn = 0; bus.ackFlags = 0; bus.dataReady = 0;
    bus7.clocksPerBit = 13'd32; bus7.stopBit2 = 1; bus7.parityEn = 0; bus7.oddParity = 0;
    bus7.msbFirst = 1; bus7.errSigEn = 0; bus7.ackFlags = 0; bus7.dataReady = 0;
    #1 nReset = 1'b0;
    tick(3);
    chk_all_zero("reset");
    nReset = 1'b1;
    tick(5);

    // 1: 8E1 lsb-first 0x3B at 372 clocks/etu
    e0 = eor_cnt; r0 = run_cnt;
    exp_q.push_back(9'h3B);
    send(9'h3B, 8, 0, 1, 0, 0, 1, 1, 372);
    tick(372);
    chk("t1 fifoLevel", int'(bus.fifoLevel), 1);
    chk("t1 dataValid", int'(bus.dataValid), 1);
    chk("t1 frameErr", int'(bus.frameErrorFlag), 0);
    chk("t1 overrun", int'(bus.overrunErrorFlag), 0);
    chk("t1 endOfRx pulses", eor_cnt - e0, 1);
    chk("t1 run seen", int'(run_cnt > r0), 1);
    bus.dataReady = 1; tick(2); bus.dataReady = 0;
    chk("t1 fifo drained", int'(bus.fifoLevel), 0);

    // 2: 100-clock low glitch, START lasts cpb/2 = 186 clocks
    e0 = eor_cnt; s0 = sb_cnt; r0 = run_cnt;
    sin = 1'b0; tick(100); sin = 1'b1; tick(400);
    chk("t2 startBit cycles", sb_cnt - s0, 186);
    chk("t2 endOfRx", eor_cnt - e0, 0);
    chk("t2 run", run_cnt - r0, 0);
    chk("t2 fifoLevel", int'(bus.fifoLevel), 0);

    // 3: 0x3F with bad parity, error signalling on: 2 etu low drive starting
    // 10.5 etu + 2 sync flops + 1 state register after the start edge
    bus.errSigEn = 1; e0 = eor_cnt; es0 = es_cnt; c0 = cyc;
    send(9'h3F, 8, 0, 1, 0, 1, 1, 1, 372);
    tick(4 * 372);
    chk("t3 errSig cycles", es_cnt - es0, 744);
    chk("t3 errSig start", es_first - c0, 3909);
    chk("t3 fifoLevel", int'(bus.fifoLevel), 0);
    chk("t3 frameErr", int'(bus.frameErrorFlag), 0);
    chk("t3 endOfRx", eor_cnt - e0, 1);
    bus.errSigEn = 0; es0 = es_cnt;
    send(9'h3F, 8, 0, 1, 0, 1, 1, 1, 372);
    tick(372);
    chk("t3b frameErr", int'(bus.frameErrorFlag), 1);
    chk("t3b fifoLevel", int'(bus.fifoLevel), 0);
    chk("t3b errSig", es_cnt - es0, 0);
    bus.ackFlags = 1; tick(1); bus.ackFlags = 0;
    chk("t3b ack clears", int'(bus.frameErrorFlag), 0);

    // 4: overrun with a 4-deep FIFO at 32 clocks/etu
    bus.clocksPerBit = 13'd32;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(9'(v));
      send(9'(v), 8, 0, 1, 0, 0, 1, 1, 32);
      tick(32);
    end
    chk("t4 fifoLevel", int'(bus.fifoLevel), 4);
    chk("t4 overrun", int'(bus.overrunErrorFlag), 1);
    bus.ackFlags = 1; tick(1); bus.ackFlags = 0;
    chk("t4 ack clears", int'(bus.overrunErrorFlag), 0);
    // ack lands in the cycle of the STOP1 match (push at posedge 339 after the edge)
    fork
      send(9'h06, 8, 0, 1, 0, 0, 1, 1, 32);
      begin tick(338); bus.ackFlags = 1; tick(1); bus.ackFlags = 0; end
    join
    tick(32);
    chk("t4 set beats ack", int'(bus.overrunErrorFlag), 1);
    chk("t4 frameErr", int'(bus.frameErrorFlag), 0);
    bus.dataReady = 1; tick(8); bus.dataReady = 0;
    chk("t4 drained", int'(bus.fifoLevel), 0);
    chk("t4 queue", exp_q.size(), 0);

    // 5: 7 bits, msb first, no parity, 2 stop bits with stop 2 low
    sel7 = 1;
    exp7_q.push_back(9'h4B);
    send(9'h4B, 7, 1, 0, 0, 0, 0, 2, 32);
    tick(32);
    chk("t5 fifoLevel", int'(bus7.fifoLevel), 1);
    chk("t5 frameErr", int'(bus7.frameErrorFlag), 1);
    chk("t5 overrun", int'(bus7.overrunErrorFlag), 0);
    bus7.dataReady = 1; tick(2); bus7.dataReady = 0;
    chk("t5 queue", exp7_q.size(), 0);
    sel7 = 0;

    // 6: reset mid-frame with two characters buffered
    bus.ackFlags = 1; tick(1); bus.ackFlags = 0;
    send(9'h11, 8, 0, 1, 0, 0, 1, 1, 32); tick(32);
    send(9'h22, 8, 0, 1, 0, 0, 1, 1, 32); tick(32);
    chk("t6 fifoLevel", int'(bus.fifoLevel), 2);
    fork
      send(9'h77, 8, 0, 1, 0, 0, 1, 1, 32);
      begin tick(100); nReset = 1'b0; #1 chk_all_zero("t6 reset"); end
    join
    exp_q.delete();
    tick(32); nReset = 1'b1; tick(32);
    chk("t6 post-reset level", int'(bus.fifoLevel), 0);
    exp_q.push_back(9'hA5);
    send(9'hA5, 8, 0, 1, 0, 0, 1, 1, 32); tick(32);
    chk("t6 A5 level", int'(bus.fifoLevel), 1);
    chk("t6 frameErr", int'(bus.frameErrorFlag), 0);
    bus.dataReady = 1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp7_q.size() != 0); i++) tick(1);
    bus.dataReady = 0;
    chk("final queues drained", exp_q.size() + exp7_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
